// File: rtl/puf_ctrl_pkg.sv
// Shared state encoding, sizing helpers and default constants for the PUF vote controller.
// No datapath; pure compile-time definitions.
package puf_ctrl_pkg;

  localparam int DEF_NUM_RUNS  = 63;
  localparam int DEF_THRESHOLD = 32;
  localparam int DEF_NUM_BITS  = 8;
  localparam int DEF_TIMEOUT   = 1023;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_SAMPLE  = 3'd3,
    S_RESOLVE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Select field width never collapses to zero, even for a single challenge.
  function automatic int sel_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Run/ones counters for one challenge plus majority and unanimity decodes; counts update one cycle after sample.
// No backpressure: clear dominates sample, and the owner guarantees at most NUM_RUNS samples between clears.
module puf_vote_counter
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_RUNS  = DEF_NUM_RUNS,
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic sample,
  input  logic response,
  output logic last_run,
  output logic vote,
  output logic unstable
);

  localparam int CW = clog2(NUM_RUNS + 1);

  logic [CW-1:0] run_cnt;
  logic [CW-1:0] ones_cnt;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      run_cnt  <= '0;
      ones_cnt <= '0;
    end else if (sample) begin
      run_cnt <= run_cnt + CW'(1);
      if (response) ones_cnt <= ones_cnt + CW'(1);
    end
  end

  // Sampled while in SAMPLE, so "this sample is the last" means the pre-increment count is NUM_RUNS-1.
  assign last_run = (run_cnt == CW'(NUM_RUNS - 1));
  assign vote     = (ones_cnt >= CW'(THRESHOLD));
  assign unstable = (ones_cnt != '0) && (ones_cnt != CW'(NUM_RUNS));

endmodule

// File: rtl/puf_vote_controller.sv
// Sequences NUM_RUNS RO evaluations per challenge over NUM_BITS challenges and majority-votes each into a response bit.
// Latency NUM_BITS*(NUM_RUNS*(R+2)+1)+1 cycles; waits on finished (bounded by TIMEOUT), EN_master low aborts or acknowledges.
module puf_vote_controller
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_RUNS  = DEF_NUM_RUNS,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int NUM_BITS  = DEF_NUM_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             EN_master,
  input  logic                             Response_1,
  input  logic                             finished,
  output logic                             EN,
  output logic                             CLR,
  output logic                             CE,
  output logic [sel_width(NUM_BITS)-1:0]   Challenge,
  output logic [NUM_BITS-1:0]              Response_master,
  output logic [NUM_BITS-1:0]              Unstable_mask,
  output logic                             Finished_master,
  output logic                             Timeout_err,
  output logic                             PUF_busy
);

  localparam int CHW = sel_width(NUM_BITS);
  localparam int TW  = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

  state_t        state;
  state_t        state_nxt;
  logic          en_latch;
  logic [TW-1:0] to_cnt;
  logic          start;
  logic          last_chal;
  logic          to_hit;
  logic          cnt_clear;
  logic          cnt_sample;
  logic          last_run;
  logic          vote;
  logic          unstable;

  assign start     = EN_master && !en_latch;
  assign last_chal = (Challenge == CHW'(NUM_BITS - 1));
  assign to_hit    = (to_cnt == TW'(TIMEOUT));
  assign cnt_clear  = (state == S_IDLE) || (state == S_RESOLVE);
  assign cnt_sample = (state == S_SAMPLE);

  puf_vote_counter #(
    .NUM_RUNS  (NUM_RUNS),
    .THRESHOLD (THRESHOLD)
  ) u_vote (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (cnt_clear),
    .sample   (cnt_sample),
    .response (Response_1),
    .last_run (last_run),
    .vote     (vote),
    .unstable (unstable)
  );

  always_comb begin
    state_nxt       = state;
    EN              = 1'b0;
    CLR             = 1'b0;
    CE              = 1'b0;
    Finished_master = 1'b0;
    PUF_busy        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        CLR       = 1'b1;
        PUF_busy  = 1'b1;
        state_nxt = EN_master ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        EN       = 1'b1;
        CE       = 1'b1;
        PUF_busy = 1'b1;
        // to_cnt==0 marks the first RUN cycle, where finished may still be stale from the previous run.
        if (!EN_master)                       state_nxt = S_IDLE;
        else if (finished && to_cnt != '0)    state_nxt = S_SAMPLE;
        else if (to_hit)                      state_nxt = S_DONE;
      end
      S_SAMPLE: begin
        EN       = 1'b1;
        PUF_busy = 1'b1;
        if (!EN_master)    state_nxt = S_IDLE;
        else if (last_run) state_nxt = S_RESOLVE;
        else               state_nxt = S_CLEAR;
      end
      S_RESOLVE: begin
        PUF_busy = 1'b1;
        if (!EN_master)     state_nxt = S_IDLE;
        else if (last_chal) state_nxt = S_DONE;
        else                state_nxt = S_CLEAR;
      end
      S_DONE: begin
        Finished_master = 1'b1;
        if (!EN_master) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= S_IDLE;
      en_latch        <= 1'b0;
      to_cnt          <= '0;
      Challenge       <= '0;
      Response_master <= '0;
      Unstable_mask   <= '0;
      Timeout_err     <= 1'b0;
    end else begin
      state    <= state_nxt;
      en_latch <= EN_master;

      if (state == S_CLEAR)                 to_cnt <= '0;
      else if (state == S_RUN && !to_hit)   to_cnt <= to_cnt + TW'(1);

      if (state == S_IDLE)
        Challenge <= '0;
      else if (state == S_RESOLVE && EN_master && !last_chal)
        Challenge <= Challenge + CHW'(1);

      // Results survive the return to IDLE and are only wiped by a new start or an abort.
      if (state == S_IDLE && start) begin
        Response_master <= '0;
        Unstable_mask   <= '0;
        Timeout_err     <= 1'b0;
      end else if (PUF_busy && !EN_master) begin
        Response_master <= '0;
        Unstable_mask   <= '0;
      end else if (state == S_RESOLVE) begin
        Response_master[Challenge] <= vote;
        Unstable_mask[Challenge]   <= unstable;
      end else if (state == S_RUN && state_nxt == S_DONE) begin
        Response_master <= '0;
        Unstable_mask   <= '1;
        Timeout_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_puf_vote_controller.sv
module tb_puf_vote_controller;
  localparam int NR = 63;
  localparam int TH = 32;
  localparam int NB = 8;
  localparam int TO = 20;
  localparam int RUN_CYC = 11;
  localparam int REQ_CYC = NB * (NR * (RUN_CYC + 2) + 1) + 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN_master = 1'b0;
  logic Response_1;
  logic finished;
  logic EN, CLR, CE;
  logic [2:0] Challenge;
  logic [NB-1:0] Response_master, Unstable_mask;
  logic Finished_master, Timeout_err, PUF_busy;

  int passed = 0;
  int total = 0;

  logic [NR-1:0] run_bits [NB];
  int ce_cnt = 0;
  int run_idx = -1;
  bit core_mute = 1'b0;

  puf_vote_controller #(
    .NUM_RUNS(NR), .THRESHOLD(TH), .NUM_BITS(NB), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .EN_master(EN_master), .Response_1(Response_1),
    .finished(finished), .EN(EN), .CLR(CLR), .CE(CE), .Challenge(Challenge),
    .Response_master(Response_master), .Unstable_mask(Unstable_mask),
    .Finished_master(Finished_master), .Timeout_err(Timeout_err), .PUF_busy(PUF_busy)
  );

  always #5 CLK = ~CLK;

  // RO core model: finished after 10 counting cycles; Response_1 from the per-run table.
  always @(posedge CLK) begin
    if (CLR) ce_cnt <= 0;
    else if (CE) ce_cnt <= ce_cnt + 1;
    if (RST || !PUF_busy || (!EN && !CLR)) run_idx <= -1;
    else if (CLR) run_idx <= run_idx + 1;
  end
  assign finished   = !core_mute && (ce_cnt >= 10);
  assign Response_1 = (run_idx >= 0 && run_idx < NR) ? run_bits[Challenge][run_idx] : 1'b0;

  function automatic logic [NR-1:0] make_bits(input int k);
    logic [NR-1:0] v;
    int n;
    int p;
    v = '0;
    n = 0;
    while (n < k) begin
      p = $urandom_range(NR - 1, 0);
      if (!v[p]) begin
        v[p] = 1'b1;
        n++;
      end
    end
    return v;
  endfunction

  task automatic model(output logic [NB-1:0] r, output logic [NB-1:0] u);
    int pop;
    for (int c = 0; c < NB; c++) begin
      pop = $countones(run_bits[c]);
      r[c] = (pop >= TH);
      u[c] = (pop != 0) && (pop != NR);
    end
  endtask

  task automatic wait_done(input int budget, inout int cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK); #1;
      cycles++;
      if (Finished_master) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_out();
    EN_master = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({EN, CLR, CE, Finished_master, Timeout_err, PUF_busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {EN, CLR, CE, Finished_master, Timeout_err, PUF_busy});
    else passed++;
    total++;
    if ({Response_master, Unstable_mask, Challenge} !== '0)
      $display("FAIL reset_data: got %h/%h/%0d expected 0/0/0", Response_master, Unstable_mask, Challenge);
    else passed++;
    RST = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (PUF_busy !== 1'b0 || CLR !== 1'b0)
      $display("FAIL reset_idle: busy=%b clr=%b expected 0 0", PUF_busy, CLR);
    else passed++;
  endtask

  task automatic test_pattern_a5();
    logic [NB-1:0] er, eu;
    int cyc;
    bit ok;
    for (int c = 0; c < NB; c++) run_bits[c] = (8'hA5 >> c) & 1 ? '1 : '0;
    model(er, eu);
    EN_master = 1'b1;
    cyc = 0;
    @(posedge CLK); #1; cyc++;
    total++;
    if (CLR !== 1'b1 || CE !== 1'b0 || PUF_busy !== 1'b1)
      $display("FAIL start_clr: clr=%b ce=%b busy=%b expected 1 0 1", CLR, CE, PUF_busy);
    else passed++;
    @(posedge CLK); #1; cyc++;
    total++;
    if (CE !== 1'b1 || CLR !== 1'b0 || EN !== 1'b1)
      $display("FAIL start_ce: ce=%b clr=%b en=%b expected 1 0 1", CE, CLR, EN);
    else passed++;
    wait_done(REQ_CYC + 100, cyc, ok);
    total++;
    if (!ok || cyc != REQ_CYC)
      $display("FAIL a5_latency: got %0d cycles (done=%0d) expected %0d", cyc, ok, REQ_CYC);
    else passed++;
    total++;
    if (Response_master !== er || Response_master !== 8'hA5)
      $display("FAIL a5_resp: got %h expected %h", Response_master, er);
    else passed++;
    total++;
    if (Unstable_mask !== eu || Timeout_err !== 1'b0 || PUF_busy !== 1'b0)
      $display("FAIL a5_mask: got %h terr=%b busy=%b expected %h 0 0", Unstable_mask, Timeout_err, PUF_busy, eu);
    else passed++;
    EN_master = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (Finished_master !== 1'b0 || Response_master !== 8'hA5)
      $display("FAIL a5_ack: fin=%b resp=%h expected 0 a5", Finished_master, Response_master);
    else passed++;
    idle_out();
  endtask

  task automatic test_vote(input string name);
    logic [NB-1:0] er, eu;
    int cyc;
    bit ok;
    model(er, eu);
    EN_master = 1'b1;
    cyc = 0;
    wait_done(REQ_CYC + 100, cyc, ok);
    total++;
    if (!ok || Response_master !== er)
      $display("FAIL %s_resp: got %h (done=%0d) expected %h", name, Response_master, ok, er);
    else passed++;
    total++;
    if (Unstable_mask !== eu || Timeout_err !== 1'b0)
      $display("FAIL %s_mask: got %h terr=%b expected %h 0", name, Unstable_mask, Timeout_err, eu);
    else passed++;
    idle_out();
  endtask

  task automatic test_unstable_bit3();
    for (int c = 0; c < NB; c++) run_bits[c] = '0;
    run_bits[3] = make_bits(32);
    test_vote("bit3");
    total++;
    if (Response_master !== 8'h08 || Unstable_mask !== 8'h08)
      $display("FAIL bit3_abs: got %h/%h expected 08/08", Response_master, Unstable_mask);
    else passed++;
  endtask

  task automatic test_threshold_minus_one();
    for (int c = 0; c < NB; c++) run_bits[c] = '1;
    run_bits[0] = make_bits(TH - 1);
    test_vote("thm1");
    total++;
    if (Response_master[0] !== 1'b0 || Unstable_mask[0] !== 1'b1)
      $display("FAIL thm1_bit0: got %b/%b expected 0/1", Response_master[0], Unstable_mask[0]);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < NB; c++) run_bits[c] = make_bits($urandom_range(NR, 0));
    test_vote("rand");
  endtask

  task automatic test_abort();
    bit ok;
    for (int c = 0; c < NB; c++) run_bits[c] = make_bits($urandom_range(NR, 0));
    EN_master = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < REQ_CYC; i++) begin
      @(posedge CLK); #1;
      if (Challenge == 3'd4 && CE) begin
        ok = 1'b1;
        break;
      end
    end
    EN_master = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (!ok || EN !== 1'b0 || CE !== 1'b0 || PUF_busy !== 1'b0)
      $display("FAIL abort_ctrl: reached=%0d en=%b ce=%b busy=%b expected 1 0 0 0", ok, EN, CE, PUF_busy);
    else passed++;
    total++;
    if (Response_master !== '0 || Unstable_mask !== '0 || Finished_master !== 1'b0)
      $display("FAIL abort_data: got %h/%h fin=%b expected 0/0 0", Response_master, Unstable_mask, Finished_master);
    else passed++;
    EN_master = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (CLR !== 1'b1 || Challenge !== 3'd0)
      $display("FAIL abort_restart: clr=%b chal=%0d expected 1 0", CLR, Challenge);
    else passed++;
    idle_out();
  endtask

  task automatic test_timeout();
    int runs;
    bit ok;
    core_mute = 1'b1;
    EN_master = 1'b1;
    runs = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (CE) runs++;
      if (Finished_master) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || runs != TO + 1)
      $display("FAIL to_runs: got %0d run cycles (done=%0d) expected %0d", runs, ok, TO + 1);
    else passed++;
    total++;
    if (Timeout_err !== 1'b1 || Response_master !== 8'h00 || Unstable_mask !== 8'hFF)
      $display("FAIL to_result: got terr=%b %h/%h expected 1 00/ff", Timeout_err, Response_master, Unstable_mask);
    else passed++;
    core_mute = 1'b0;
    idle_out();
  endtask

  task automatic test_reset_during_run();
    bit ok;
    EN_master = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (CE && Challenge == 3'd0 && i > 30) begin
        ok = 1'b1;
        break;
      end
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (!ok || {EN, CLR, CE, Finished_master, Timeout_err, PUF_busy} !== 6'b0 ||
        {Response_master, Unstable_mask, Challenge} !== '0)
      $display("FAIL rst_run: reached=%0d ctrl=%b data=%h expected 1 0 0", ok,
               {EN, CLR, CE, Finished_master, Timeout_err, PUF_busy}, {Response_master, Unstable_mask, Challenge});
    else passed++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (CLR !== 1'b1 || PUF_busy !== 1'b1)
      $display("FAIL rst_high_start: clr=%b busy=%b expected 1 1", CLR, PUF_busy);
    else passed++;
    @(posedge CLK); #1;
    total++;
    if (CE !== 1'b1)
      $display("FAIL rst_high_ce: ce=%b expected 1", CE);
    else passed++;
    idle_out();
  endtask

  initial begin
    for (int c = 0; c < NB; c++) run_bits[c] = '0;
    test_reset();
    test_pattern_a5();
    test_unstable_bit3();
    test_threshold_minus_one();
    test_abort();
    test_timeout();
    test_random();
    test_reset_during_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
